// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared between spi_master and spi_slave_rx.
// Holds the frame width and the receiver state encoding.
package spi_pkg;

    // Payload width of one SPI frame, common to master and slave.
    localparam int unsigned WORD_W = 12;

    // Receiver sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StDummy,
        StShift,
        StWaitCs
    } rx_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: receive-word storage for spi_slave_rx.
// With SPI_SLAVE_RX_FIFO_EN defined, this is a DEPTH-entry FIFO.
// Without it, this is a single holding register and DEPTH is ignored.
// A push while full is dropped with an ovf pulse, unless a pop happens in the same cycle.
module spi_rx_fifo #(
    parameter int unsigned WORD_W = spi_pkg::WORD_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              dready,
    output logic [WORD_W-1:0] dout,
    output logic              dvalid,
    output logic              ovf
);

    logic pop;
    logic full;
    logic push_ok;

`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;

    // Occupancy flags, handshake and next-state for pointers and count.
    always_comb begin
        full     = (cnt_q == (PTR_W + 1)'(DEPTH));
        dvalid   = (cnt_q != '0);
        pop      = dvalid & dready;
        // A pop in the same cycle frees the slot the new word needs.
        push_ok  = push & (~full | pop);
        ovf      = push & full & ~pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        // Gate the head so dout reads zero whenever storage is empty.
        dout = dvalid ? mem_q[rd_ptr_q] : '0;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
`else
    logic [WORD_W-1:0] hold_q;
    logic              valid_q;
    logic              unused_depth;

    assign unused_depth = ^DEPTH;

    // Single-entry handshake: full is simply the valid flag.
    always_comb begin
        full    = valid_q;
        dvalid  = valid_q;
        dout    = hold_q;
        pop     = valid_q & dready;
        push_ok = push & (~full | pop);
        ovf     = push & full & ~pop;
    end

    // Holding register: load on accepted push, clear valid on a bare pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else if (push_ok) begin
            hold_q  <= push_data;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI receive-only slave, LSB first, data sampled on sclk falling edges.
// The first falling edge after cs falls is a dummy and is discarded.
// Storage depth is selected by SPI_SLAVE_RX_FIFO_EN (FIFO of DEPTH words, else one register).
module spi_slave_rx #(
    parameter int unsigned WORD_W      = spi_pkg::WORD_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    input  logic              dready,
    output logic [WORD_W-1:0] dout,
    output logic              dvalid,
    output logic              frm_err,
    output logic              ovf
);

    import spi_pkg::*;

    localparam int unsigned CNT_W = $clog2(WORD_W);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_prev_q;
    logic                   sclk_fall;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic                   clear;
    logic                   shift_en;
    logic                   last_bit;
    logic                   push;

    // Input synchronizers; cs idles high so reset leaves the bus deselected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign last_bit  = (cnt_q == CNT_W'(WORD_W - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: cs high aborts any frame in progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (!cs_s) state_d = StDummy;
            StDummy: begin
                if (cs_s)           state_d = StIdle;
                else if (sclk_fall) state_d = StShift;
            end
            StShift: begin
                if (cs_s)                       state_d = StIdle;
                else if (sclk_fall && last_bit) state_d = StWaitCs;
            end
            StWaitCs: if (cs_s) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs of the FSM: datapath controls and the frame-error pulse.
    always_comb begin
        clear    = 1'b0;
        shift_en = 1'b0;
        push     = 1'b0;
        frm_err  = 1'b0;
        case (state_q)
            StIdle:  clear = 1'b1;
            StDummy: frm_err = cs_s;
            StShift: begin
                if (cs_s) begin
                    frm_err = 1'b1;
                end else if (sclk_fall) begin
                    shift_en = 1'b1;
                    push     = last_bit;
                end
            end
            default: ;
        endcase
    end

    // Shift datapath next-state; the pushed word includes the bit sampled this cycle.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d[cnt_q] = mosi_s;
            cnt_d          = cnt_q + CNT_W'(1);
        end
    end

    // Bit counter and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    spi_rx_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift_d),
        .dready    (dready),
        .dout      (dout),
        .dvalid    (dvalid),
        .ovf       (ovf)
    );

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: self-checking bench for spi_slave_rx.
// Expected words come from a queue model of the storage (capacity DEPTH with
// SPI_SLAVE_RX_FIFO_EN, else 1); a monitor logs every accepted word and pulse.
module tb_spi_slave_rx;

    localparam int unsigned WORD_W      = 12;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEPTH       = 4;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int unsigned CAP = DEPTH;
`else
    localparam int unsigned CAP = 1;
`endif
    localparam int HALF = 4;

    logic              clk, rst, sclk, cs, mosi, dready;
    logic [WORD_W-1:0] dout;
    logic              dvalid, frm_err, ovf;

    spi_slave_rx #(
        .WORD_W      (WORD_W),
        .SYNC_STAGES (SYNC_STAGES),
        .DEPTH       (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .dready  (dready),
        .dout    (dout),
        .dvalid  (dvalid),
        .frm_err (frm_err),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor-owned logs.
    logic [WORD_W-1:0] got_q[$];
    int                frm_cnt = 0;
    int                ovf_cnt = 0;
    logic              prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_dout = '0;

    // Model state.
    logic [WORD_W-1:0] exp_store[$];
    logic [WORD_W-1:0] exp_out[$];
    int                exp_ovf;
    int                got_base, frm_base, ovf_base;

    // Sample just after the falling clk edge, once drivers have settled.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (dvalid !== 1'b1 || dout !== prev_dout) begin
                    errors++;
                    $display("FAIL stall_hold: dvalid=%b dout=%h, required dvalid=1 dout=%h",
                             dvalid, dout, prev_dout);
                end
            end
            if (dvalid === 1'b1 && dready === 1'b1) got_q.push_back(dout);
            if (frm_err === 1'b1) frm_cnt++;
            if (ovf === 1'b1) ovf_cnt++;
            prev_stall = (dvalid === 1'b1) && (dready === 1'b0);
            prev_dout  = dout;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: cs low, one dummy falling edge, then nbits data bits LSB first.
    // pop_last raises dready for exactly the cycle in which the last bit is pushed.
    task automatic send_bits(input logic [WORD_W-1:0] w, input int nbits, input bit pop_last);
        cs = 1'b0;
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[i];
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            if (pop_last && i == WORD_W - 1) begin
                wait_clk(SYNC_STAGES);
                dready = 1'b1;
                wait_clk(1);
                dready = 1'b0;
                wait_clk(HALF - SYNC_STAGES - 1);
            end else begin
                wait_clk(HALF);
            end
        end
    endtask

    task automatic end_frame();
        cs   = 1'b1;
        mosi = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic send_frame(input logic [WORD_W-1:0] w, input bit pop_last);
        send_bits(w, WORD_W, pop_last);
        end_frame();
    endtask

    function automatic void model_push(input logic [WORD_W-1:0] w);
        if (exp_store.size() < CAP) exp_store.push_back(w);
        else exp_ovf++;
    endfunction

    function automatic void model_pop();
        if (exp_store.size() > 0) exp_out.push_back(exp_store.pop_front());
    endfunction

    task automatic drain();
        dready = 1'b1;
        wait_clk(CAP + 4);
        dready = 1'b0;
        wait_clk(2);
        while (exp_store.size() > 0) model_pop();
    endtask

    task automatic start_test();
        got_base = got_q.size();
        frm_base = frm_cnt;
        ovf_base = ovf_cnt;
        exp_out.delete();
        exp_ovf = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; dready = 1'b0;
        wait_clk(3);
        checks++;
        if ({dout, dvalid, frm_err, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dout=%h dvalid=%b frm_err=%b ovf=%b, required all 0",
                     dout, dvalid, frm_err, ovf);
        end
        rst = 1'b0;
        wait_clk(4);
        checks++;
        if (dvalid !== 1'b0 || frm_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: dvalid=%b frm_err=%b, required 0 0", dvalid, frm_err);
        end
    endtask

    task automatic test_single();
        start_test();
        dready = 1'b1;
        send_frame(12'hA5C, 1'b0);
        model_push(12'hA5C);
        model_pop();
        dready = 1'b0;
        checks++;
        if (got_q.size() - got_base !== 1 || got_q[got_base] !== 12'hA5C) begin
            errors++;
            $display("FAIL single_word: %0d words, first %h, required 1 word %h",
                     got_q.size() - got_base, got_q[got_base], exp_out[0]);
        end
        checks++;
        if (frm_cnt - frm_base !== 0) begin
            errors++;
            $display("FAIL single_frm_err: %0d pulses, required 0", frm_cnt - frm_base);
        end
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] words [3];
        words = '{12'h001, 12'h800, 12'hFFF};
        start_test();
        dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_frame(words[i], 1'b0);
            model_push(words[i]);
        end
        checks++;
        if (dvalid !== 1'b1 || dout !== exp_store[0]) begin
            errors++;
            $display("FAIL b2b_head: dvalid=%b dout=%h, required 1 %h", dvalid, dout, exp_store[0]);
        end
        drain();
        checks++;
        if (got_q.size() - got_base !== exp_out.size()) begin
            errors++;
            $display("FAIL b2b_count: %0d words, required %0d", got_q.size() - got_base, exp_out.size());
        end
        for (int i = 0; i < exp_out.size() && got_base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[got_base + i] !== exp_out[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h, required %h", i, got_q[got_base + i], exp_out[i]);
            end
        end
        checks++;
        if (ovf_cnt - ovf_base !== exp_ovf) begin
            errors++;
            $display("FAIL b2b_ovf: %0d pulses, required %0d", ovf_cnt - ovf_base, exp_ovf);
        end
    endtask

    task automatic test_overflow();
        start_test();
        dready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(WORD_W'(i), 1'b0);
            model_push(WORD_W'(i));
        end
        checks++;
        if (ovf_cnt - ovf_base !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_pulses: %0d, required %0d", ovf_cnt - ovf_base, exp_ovf);
        end
        drain();
        checks++;
        if (got_q.size() - got_base !== exp_out.size()) begin
            errors++;
            $display("FAIL ovf_kept: %0d words, required %0d", got_q.size() - got_base, exp_out.size());
        end
        for (int i = 0; i < exp_out.size() && got_base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[got_base + i] !== exp_out[i]) begin
                errors++;
                $display("FAIL ovf_word%0d: got %h, required %h", i, got_q[got_base + i], exp_out[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [WORD_W-1:0] w;
        w = WORD_W'($urandom);
        start_test();
        dready = 1'b1;
        send_bits(w, 5, 1'b0);
        end_frame();
        checks++;
        if (frm_cnt - frm_base !== 1 || got_q.size() - got_base !== 0) begin
            errors++;
            $display("FAIL abort: frm_err pulses %0d words %0d, required 1 and 0",
                     frm_cnt - frm_base, got_q.size() - got_base);
        end
        send_frame(12'h3C3, 1'b0);
        model_push(12'h3C3);
        model_pop();
        dready = 1'b0;
        checks++;
        if (got_q.size() - got_base !== 1 || got_q[got_base] !== exp_out[0]) begin
            errors++;
            $display("FAIL abort_next: %0d words first %h, required 1 word %h",
                     got_q.size() - got_base, got_q[got_base], exp_out[0]);
        end
        checks++;
        if (frm_cnt - frm_base !== 1) begin
            errors++;
            $display("FAIL abort_frm_total: %0d pulses, required 1", frm_cnt - frm_base);
        end
    endtask

    task automatic test_reset_midframe();
        logic [WORD_W-1:0] w;
        w = WORD_W'($urandom);
        start_test();
        dready = 1'b0;
        send_frame(12'h5A5, 1'b0);
        model_push(12'h5A5);
        checks++;
        if (dvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: dvalid=%b, required 1", dvalid);
        end
        send_bits(w, 7, 1'b0);
        mosi = w[7];
        sclk = 1'b1;
        wait_clk(1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout, dvalid, frm_err, ovf} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: dout=%h dvalid=%b frm_err=%b ovf=%b, required all 0",
                     dout, dvalid, frm_err, ovf);
        end
        exp_store.delete();
        wait_clk(3);
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(4);
        dready = 1'b1;
        send_frame(12'h0F0, 1'b0);
        model_push(12'h0F0);
        model_pop();
        dready = 1'b0;
        checks++;
        if (got_q.size() - got_base !== 1 || got_q[got_base] !== exp_out[0]) begin
            errors++;
            $display("FAIL rstmid_next: %0d words first %h, required 1 word %h",
                     got_q.size() - got_base, got_q[got_base], exp_out[0]);
        end
        checks++;
        if (frm_cnt - frm_base !== 0 || ovf_cnt - ovf_base !== 0) begin
            errors++;
            $display("FAIL rstmid_pulses: frm_err %0d ovf %0d, required 0 0",
                     frm_cnt - frm_base, ovf_cnt - ovf_base);
        end
    endtask

    task automatic test_full_pop_push();
        logic [WORD_W-1:0] w;
        start_test();
        dready = 1'b0;
        for (int i = 0; i < CAP; i++) begin
            w = WORD_W'($urandom);
            send_frame(w, 1'b0);
            model_push(w);
        end
        w = WORD_W'($urandom);
        send_frame(w, 1'b1);
        model_pop();
        model_push(w);
        checks++;
        if (ovf_cnt - ovf_base !== exp_ovf) begin
            errors++;
            $display("FAIL popush_ovf: %0d pulses, required %0d", ovf_cnt - ovf_base, exp_ovf);
        end
        checks++;
        if (dvalid !== 1'b1 || dout !== exp_store[0]) begin
            errors++;
            $display("FAIL popush_head: dvalid=%b dout=%h, required 1 %h", dvalid, dout, exp_store[0]);
        end
        drain();
        checks++;
        if (got_q.size() - got_base !== exp_out.size()) begin
            errors++;
            $display("FAIL popush_count: %0d words, required %0d", got_q.size() - got_base, exp_out.size());
        end
        for (int i = 0; i < exp_out.size() && got_base + i < got_q.size(); i++) begin
            checks++;
            if (got_q[got_base + i] !== exp_out[i]) begin
                errors++;
                $display("FAIL popush_word%0d: got %h, required %h", i, got_q[got_base + i], exp_out[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n;
            logic [WORD_W-1:0] w;
            n = int'($urandom_range(CAP + 2, 1));
            start_test();
            dready = 1'b0;
            for (int i = 0; i < n; i++) begin
                w = WORD_W'($urandom);
                send_frame(w, 1'b0);
                model_push(w);
            end
            drain();
            checks++;
            if (got_q.size() - got_base !== exp_out.size() || ovf_cnt - ovf_base !== exp_ovf) begin
                errors++;
                $display("FAIL rand%0d_count: words %0d ovf %0d, required %0d %0d", r,
                         got_q.size() - got_base, ovf_cnt - ovf_base, exp_out.size(), exp_ovf);
            end
            for (int i = 0; i < exp_out.size() && got_base + i < got_q.size(); i++) begin
                checks++;
                if (got_q[got_base + i] !== exp_out[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d: got %h, required %h", r, i,
                             got_q[got_base + i], exp_out[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_abort();
        test_reset_midframe();
        test_full_pop_push();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter: WORD_W, 12, bits per frame; matches the 12-bit spi_master payload.
REQ-002 Parameter: SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2).
REQ-003 Parameter: DEPTH, 4, receive FIFO entries (power of two); used only when SPI_SLAVE_RX_FIFO_EN is defined.
REQ-004 Port: clk  input  1  system clock (100 MHz); the only clock, and all state is on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: sclk  input  1  serial clock from spi_master, asynchronous to clk.
REQ-007 Port: cs  input  1  active-low chip select from spi_master.
REQ-008 Port: mosi  input  1  serial data from spi_master, LSB first.
REQ-009 Port: dready  input  1  consumer accepts dout when dready and dvalid are both high.
REQ-010 Port: dout  output  WORD_W  received word, valid while dvalid is high.
REQ-011 Port: dvalid  output  1  a word is available.
REQ-012 Port: frm_err  output  1  one-clk pulse when a frame is aborted early.
REQ-013 Port: ovf  output  1  one-clk pulse when a complete word is dropped because storage is full.

Function
REQ-014 The block SHALL pass sclk, cs and mosi through SYNC_STAGES-flop synchronizers and use only the synchronized copies.
REQ-015 The block SHALL detect sclk falling edges as synchronized previous value 1 and current value 0.
REQ-016 The state machine SHALL have four states: IDLE, DUMMY, SHIFT and WAIT_CS.
REQ-017 IDLE SHALL go to DUMMY when synchronized cs is low; it SHALL clear the bit counter and the shift register.
REQ-018 DUMMY SHALL discard the first sclk falling edge after cs falls, then go to SHIFT; mosi is not yet valid on that edge.
REQ-019 SHIFT SHALL sample mosi into bit position count on each falling edge, LSB first, then increment count.
REQ-020 On the falling edge that captures bit WORD_W-1, the block SHALL push the word into storage in the same cycle and go to WAIT_CS.
REQ-021 WAIT_CS SHALL ignore further sclk edges and return to IDLE when synchronized cs is high.
REQ-022 Synchronized cs high in DUMMY or SHIFT SHALL discard the partial word, pulse frm_err for one clk and go to IDLE.
REQ-023 Latency: dvalid SHALL rise on the clk after the capturing falling edge is detected, provided storage was empty.
REQ-024 The block SHALL remove a word from storage in any cycle where dvalid and dready are both high.
REQ-025 A push while storage is full SHALL drop the new word and pulse ovf, unless a pop happens in the same cycle; a simultaneous pop and push SHALL succeed.
REQ-026 dout and dvalid SHALL stay stable while dvalid is high and dready is low.

Reset
REQ-027 While rst is high, the block SHALL asynchronously force: state IDLE, count 0, shift register 0, synchronizer flops sclk=0, cs=1, mosi=0, storage empty.
REQ-028 While rst is high, the outputs SHALL be dout=0, dvalid=0, frm_err=0, ovf=0.
REQ-029 Reset asserted mid-frame SHALL drop the partial word without a frm_err pulse.
REQ-030 After rst falls, reception SHALL begin only at the next cs falling transition seen in IDLE.

Configuration
REQ-031 With SPI_SLAVE_RX_FIFO_EN defined, storage SHALL be a DEPTH-entry first-in first-out buffer with wrap-around pointers and an occupancy count 0..DEPTH.
REQ-032 Without SPI_SLAVE_RX_FIFO_EN, storage SHALL be a single holding register with full equal to dvalid, and DEPTH SHALL be ignored.

Structure
REQ-033 Package spi_pkg SHALL hold the state enumeration and the constant WORD_W=12 shared with spi_master.
REQ-034 Sub-module spi_rx_fifo SHALL implement storage, including the push, pop and ovf logic and both macro variants.

Verification
REQ-035 Test 1: spi_master sends din=12'hA5C through spi_slave_rx with dready=1 -> exactly one dvalid pulse with dout=12'hA5C, and no frm_err.
REQ-036 Test 2: three back-to-back frames 12'h001, 12'h800, 12'hFFF are sent with dready=0, then dready is raised -> the words pop in order; no ovf when the FIFO is enabled.
REQ-037 Test 3: five frames are sent with dready=0, the FIFO enabled and DEPTH=4 -> ovf pulses once and the first four words are kept; without the macro, ovf pulses four times and 12'h001 is kept.
REQ-038 Test 4: cs is raised after 5 bits -> one frm_err pulse, no dvalid, and the next full frame 12'h3C3 is received correctly.
REQ-039 Test 5: rst is asserted during bit 7 of a frame -> all outputs are 0 immediately, and the next frame 12'h0F0 is received intact.
REQ-040 Test 6: the FIFO is full and dready=1 in the same cycle a new word completes -> no ovf, and the occupancy stays at 4.
